// File: rtl/mult_pkg.sv
// mult_pkg: shared widths and state encoding for the array-multiplier datapath
package mult_pkg;
    localparam int DEF_N = 4;
    function automatic int prod_w(input int n);
        return 2 * n;
    endfunction
    typedef enum logic {ST_ACCUM = 1'b0, ST_HOLD = 1'b1} state_t;
endpackage

// File: rtl/product_accumulator.sv
// product_accumulator: sums LEN unsigned products per block, holds the sum until taken
module product_accumulator
    import mult_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int ACC_W = 12,
    parameter int LEN   = 8,
    parameter int CNT_W = $clog2(LEN + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [prod_w(N)-1:0]   p,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ACC_W-1:0]       out_sum,
    output logic                   out_ovf,
    output logic                   busy
);
    state_t             r_state, w_nxt_state;
    logic [ACC_W-1:0]   r_acc, w_nxt_acc, r_sum;
    logic [CNT_W-1:0]   r_cnt, w_nxt_cnt;
    logic               r_ovf, w_nxt_ovf, r_sum_ovf, w_load, w_last;
    logic [ACC_W:0]     w_sum;
    // extra top bit of w_sum is the carry out of the accumulator
    assign w_sum  = {1'b0, r_acc} + {{(ACC_W + 1 - prod_w(N)){1'b0}}, p};
    assign w_last = r_cnt == CNT_W'(LEN - 1);
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_acc   = r_acc;
        w_nxt_cnt   = r_cnt;
        w_nxt_ovf   = r_ovf;
        w_load      = 1'b0;
        if (clear) begin
            w_nxt_state = ST_ACCUM;
            w_nxt_acc   = '0;
            w_nxt_cnt   = '0;
            w_nxt_ovf   = 1'b0;
        end else if (r_state == ST_HOLD) begin
            w_nxt_state = out_ready ? ST_ACCUM : ST_HOLD;
        end else if (in_valid) begin
            w_load      = w_last;
            w_nxt_state = w_last ? ST_HOLD : ST_ACCUM;
            w_nxt_acc   = w_last ? '0 : w_sum[ACC_W-1:0];
            w_nxt_cnt   = w_last ? '0 : r_cnt + 1'b1;
            w_nxt_ovf   = !w_last && (r_ovf || w_sum[ACC_W]);
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_ACCUM;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_ovf     <= 1'b0;
            r_sum     <= '0;
            r_sum_ovf <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            r_acc   <= w_nxt_acc;
            r_cnt   <= w_nxt_cnt;
            r_ovf   <= w_nxt_ovf;
            if (w_load) begin
                r_sum     <= w_sum[ACC_W-1:0];
                r_sum_ovf <= r_ovf || w_sum[ACC_W];
            end
        end
    end
    assign in_ready  = r_state == ST_ACCUM;
    assign out_valid = r_state == ST_HOLD;
    assign busy      = (r_state == ST_HOLD) || (r_cnt != '0);
    assign out_sum   = r_sum;
    assign out_ovf   = r_sum_ovf;
endmodule

// File: tb/tb_product_accumulator.sv
// tb_product_accumulator: several accumulator configurations fed from a behavioural 4x4 multiplier
module tb_product_accumulator;
    logic       clk = 1'b0, reset = 1'b1, clear = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [7:0] p = '0;
    logic [4:0] rdy, ov, ovf, bsy;
    logic [11:0] sum0, sum2, sum3, sum4;
    logic [9:0]  sum1;
    int errors = 0, checks = 0;

    always #5 clk = ~clk;

    product_accumulator #(.N(4), .ACC_W(12), .LEN(4)) dut0 (.clk(clk), .reset(reset), .clear(clear),
        .in_valid(in_valid), .in_ready(rdy[0]), .p(p), .out_valid(ov[0]), .out_ready(out_ready),
        .out_sum(sum0), .out_ovf(ovf[0]), .busy(bsy[0]));
    product_accumulator #(.N(4), .ACC_W(10), .LEN(5)) dut1 (.clk(clk), .reset(reset), .clear(clear),
        .in_valid(in_valid), .in_ready(rdy[1]), .p(p), .out_valid(ov[1]), .out_ready(out_ready),
        .out_sum(sum1), .out_ovf(ovf[1]), .busy(bsy[1]));
    product_accumulator #(.N(4), .ACC_W(12), .LEN(2)) dut2 (.clk(clk), .reset(reset), .clear(clear),
        .in_valid(in_valid), .in_ready(rdy[2]), .p(p), .out_valid(ov[2]), .out_ready(out_ready),
        .out_sum(sum2), .out_ovf(ovf[2]), .busy(bsy[2]));
    product_accumulator #(.N(4), .ACC_W(12), .LEN(3)) dut3 (.clk(clk), .reset(reset), .clear(clear),
        .in_valid(in_valid), .in_ready(rdy[3]), .p(p), .out_valid(ov[3]), .out_ready(out_ready),
        .out_sum(sum3), .out_ovf(ovf[3]), .busy(bsy[3]));
    product_accumulator #(.N(4), .ACC_W(12), .LEN(1)) dut4 (.clk(clk), .reset(reset), .clear(clear),
        .in_valid(in_valid), .in_ready(rdy[4]), .p(p), .out_valid(ov[4]), .out_ready(out_ready),
        .out_sum(sum4), .out_ovf(ovf[4]), .busy(bsy[4]));

    // stands in for the array multiplier in front of the accumulator
    function automatic logic [7:0] mul(input logic [3:0] a, input logic [3:0] b);
        return {4'b0, a} * {4'b0, b};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 0; clear = 0; out_ready = 0; reset = 1;
        tick();
        reset = 0;
    endtask

    task automatic push(input logic [7:0] v);
        in_valid = 1; p = v;
        tick();
        in_valid = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (rdy[0] !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", rdy[0]); end
        checks++; if (ov[0] !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", ov[0]); end
        checks++; if (bsy[0] !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bsy[0]); end
        checks++; if (sum0 !== 12'd0) begin errors++; $display("FAIL reset_sum got=%0d exp=0", sum0); end
        checks++; if (ovf[0] !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", ovf[0]); end
    endtask

    task automatic test_back_to_back();
        int total = 0;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1; p = mul(4'd15, 4'd15); total += p;
            tick();
            checks++; if (bsy[0] !== 1'b1) begin errors++; $display("FAIL b2b_busy[%0d] got=%b exp=1", i, bsy[0]); end
            checks++; if (ov[0] !== 1'(i == 3)) begin errors++; $display("FAIL b2b_valid[%0d] got=%b exp=%b", i, ov[0], i == 3); end
        end
        in_valid = 0;
        checks++; if (sum0 !== 12'(total % 4096)) begin errors++; $display("FAIL b2b_sum got=%0d exp=%0d", sum0, total % 4096); end
        checks++; if (ovf[0] !== 1'(total >= 4096)) begin errors++; $display("FAIL b2b_ovf got=%b exp=%b", ovf[0], total >= 4096); end
    endtask

    task automatic test_overflow();
        int total = 0;
        do_reset();
        for (int i = 0; i < 5; i++) begin push(mul(4'd15, 4'd15)); total += 225; end
        checks++; if (ov[1] !== 1'b1) begin errors++; $display("FAIL ovf_valid got=%b exp=1", ov[1]); end
        checks++; if (sum1 !== 10'(total % 1024)) begin errors++; $display("FAIL ovf_sum got=%0d exp=%0d", sum1, total % 1024); end
        checks++; if (ovf[1] !== 1'(total >= 1024)) begin errors++; $display("FAIL ovf_flag got=%b exp=%b", ovf[1], total >= 1024); end
        out_ready = 1; tick(); out_ready = 0;
        checks++; if (ov[1] !== 1'b0 || rdy[1] !== 1'b1) begin errors++; $display("FAIL ovf_release got=%b%b exp=01", ov[1], rdy[1]); end
        total = 0;
        for (int i = 1; i <= 5; i++) begin push(mul(4'(i), 4'd1)); total += i; end
        checks++; if (sum1 !== 10'(total % 1024)) begin errors++; $display("FAIL ovf_sum2 got=%0d exp=%0d", sum1, total % 1024); end
        checks++; if (ovf[1] !== 1'b0) begin errors++; $display("FAIL ovf_sticky_cleared got=%b exp=0", ovf[1]); end
    endtask

    task automatic test_backpressure();
        do_reset();
        push(mul(4'd2, 4'd3));
        push(mul(4'd3, 4'd3));
        checks++; if (ov[2] !== 1'b1 || sum2 !== 12'd15) begin errors++; $display("FAIL bp_first got=%b/%0d exp=1/15", ov[2], sum2); end
        in_valid = 1; p = 8'd100;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (rdy[2] !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d] got=%b exp=0", i, rdy[2]); end
            checks++; if (sum2 !== 12'd15 || ov[2] !== 1'b1) begin errors++; $display("FAIL bp_hold[%0d] got=%b/%0d exp=1/15", i, ov[2], sum2); end
        end
        out_ready = 1; tick(); out_ready = 0;
        checks++; if (rdy[2] !== 1'b1 || bsy[2] !== 1'b0) begin errors++; $display("FAIL bp_release got=rdy%b busy%b exp=rdy1 busy0", rdy[2], bsy[2]); end
        tick();
        checks++; if (bsy[2] !== 1'b1 || ov[2] !== 1'b0) begin errors++; $display("FAIL bp_pending_accept got=busy%b valid%b exp=busy1 valid0", bsy[2], ov[2]); end
        push(8'd1);
        checks++; if (ov[2] !== 1'b1 || sum2 !== 12'd101) begin errors++; $display("FAIL bp_second got=%b/%0d exp=1/101", ov[2], sum2); end
    endtask

    task automatic test_gaps();
        do_reset();
        push(8'd10);
        tick(); tick();
        checks++; if (bsy[3] !== 1'b1) begin errors++; $display("FAIL gap_busy got=%b exp=1", bsy[3]); end
        push(8'd20);
        tick();
        checks++; if (ov[3] !== 1'b0) begin errors++; $display("FAIL gap_early_valid got=%b exp=0", ov[3]); end
        push(8'd30);
        checks++; if (ov[3] !== 1'b1 || sum3 !== 12'd60) begin errors++; $display("FAIL gap_sum got=%b/%0d exp=1/60", ov[3], sum3); end
    endtask

    task automatic test_clear();
        do_reset();
        push(8'd50);
        push(8'd60);
        clear = 1; in_valid = 1; p = 8'd70;
        tick();
        clear = 0; in_valid = 0;
        checks++; if (bsy[0] !== 1'b0 || rdy[0] !== 1'b1 || ov[0] !== 1'b0) begin
            errors++; $display("FAIL clear_state got=busy%b rdy%b valid%b exp=busy0 rdy1 valid0", bsy[0], rdy[0], ov[0]); end
        for (int i = 0; i < 4; i++) push(8'd1);
        checks++; if (ov[0] !== 1'b1 || sum0 !== 12'd4) begin errors++; $display("FAIL clear_sum got=%b/%0d exp=1/4", ov[0], sum0); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        push(mul(4'd7, 4'd8));
        push(mul(4'd9, 4'd9));
        reset = 1; tick(); reset = 0;
        checks++; if (ov[0] !== 1'b0 || rdy[0] !== 1'b1 || bsy[0] !== 1'b0 || sum0 !== 12'd0) begin
            errors++; $display("FAIL rst_mid got=valid%b rdy%b busy%b sum%0d exp=valid0 rdy1 busy0 sum0", ov[0], rdy[0], bsy[0], sum0); end
        for (int i = 1; i <= 4; i++) push(mul(4'(i), 4'(i)));
        checks++; if (ov[0] !== 1'b1 || sum0 !== 12'd30) begin errors++; $display("FAIL rst_mid_sum got=%b/%0d exp=1/30", ov[0], sum0); end
        reset = 1; tick(); reset = 0;
        checks++; if (ov[0] !== 1'b0 || rdy[0] !== 1'b1 || bsy[0] !== 1'b0 || sum0 !== 12'd0) begin
            errors++; $display("FAIL rst_hold got=valid%b rdy%b busy%b sum%0d exp=valid0 rdy1 busy0 sum0", ov[0], rdy[0], bsy[0], sum0); end
        for (int i = 0; i < 4; i++) push(8'd200);
        checks++; if (ov[0] !== 1'b1 || sum0 !== 12'd800) begin errors++; $display("FAIL rst_hold_sum got=%b/%0d exp=1/800", ov[0], sum0); end
    endtask

    task automatic test_len1();
        logic [7:0] v;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            v = mul(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            push(v);
            checks++; if (ov[4] !== 1'b1 || sum4 !== 12'(v)) begin errors++; $display("FAIL len1[%0d] got=%b/%0d exp=1/%0d", i, ov[4], sum4, v); end
            out_ready = 1; tick(); out_ready = 0;
        end
    endtask

    task automatic test_random();
        int total, g;
        logic [7:0] v;
        do_reset();
        for (int b = 0; b < 25; b++) begin
            total = 0;
            for (int j = 0; j < 5; j++) begin
                g = $urandom_range(0, 2);
                for (int k = 0; k < g; k++) begin
                    tick();
                    checks++; if (ov[1] !== 1'b0) begin errors++; $display("FAIL rnd_gap_valid[%0d] got=%b exp=0", b, ov[1]); end
                end
                v = mul(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
                push(v);
                total += v;
            end
            checks++; if (ov[1] !== 1'b1) begin errors++; $display("FAIL rnd_valid[%0d] got=%b exp=1", b, ov[1]); end
            checks++; if (sum1 !== 10'(total % 1024)) begin errors++; $display("FAIL rnd_sum[%0d] got=%0d exp=%0d", b, sum1, total % 1024); end
            checks++; if (ovf[1] !== 1'(total >= 1024)) begin errors++; $display("FAIL rnd_ovf[%0d] got=%b exp=%b", b, ovf[1], total >= 1024); end
            g = $urandom_range(0, 3);
            for (int k = 0; k < g; k++) begin
                in_valid = 1'($urandom_range(0, 1)); p = 8'($urandom_range(0, 255));
                tick();
                checks++; if (ov[1] !== 1'b1 || sum1 !== 10'(total % 1024)) begin
                    errors++; $display("FAIL rnd_hold[%0d] got=%b/%0d exp=1/%0d", b, ov[1], sum1, total % 1024); end
            end
            in_valid = 0; out_ready = 1; tick(); out_ready = 0;
            checks++; if (ov[1] !== 1'b0 || rdy[1] !== 1'b1 || bsy[1] !== 1'b0) begin
                errors++; $display("FAIL rnd_release[%0d] got=valid%b rdy%b busy%b exp=valid0 rdy1 busy0", b, ov[1], rdy[1], bsy[1]); end
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_overflow();
        test_backpressure();
        test_gaps();
        test_clear();
        test_reset_mid();
        test_len1();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
